// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the slide-switch debounce bank.
// State encoding is chosen so bit 1 equals the accepted level while settled.
package sw_debounce_pkg;

  localparam int NUM_SW        = 8;
  localparam int DB_CYCLES_DEF = 250000;

  typedef enum logic [1:0] {
    ST_LO      = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_HI      = 2'b11,
    ST_WAIT_LO = 2'b10
  } db_state_e;

  // Counter width for a debounce window; never below one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce_bank_if.sv
// Switch bundle between the board pins and the game FSM: raw pins in, clean levels and pulses out.
// The debounce bank takes the slave side; the consumer (or bench) takes the master side.
interface sw_debounce_bank_if
  import sw_debounce_pkg::*;
#(
  parameter int N_SW = NUM_SW
);

  logic [N_SW-1:0] sw_in;
  logic [N_SW-1:0] sw_level;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic            sw_any_edge;

  modport master (
    output sw_in,
    input  sw_level,
    input  sw_rise,
    input  sw_fall,
    input  sw_any_edge
  );

  modport slave (
    input  sw_in,
    output sw_level,
    output sw_rise,
    output sw_fall,
    output sw_any_edge
  );

endinterface

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-FF synchronizer, counter debouncer FSM, registered edge pulses.
// A level held from sampling edge k is accepted at edge k+DB_CYCLES+2; no backpressure.
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Only the second synchronizer stage is allowed to steer the FSM.
  always_comb begin
    sync1_d = sw_in;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      ST_LO: begin
        if (sync2_q) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!sync2_q) begin
          state_d = ST_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HI: begin
        if (!sync2_q) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (sync2_q) begin
          state_d = ST_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/sw_debounce_bank.sv
// Bank of N_SW independent debounce channels plus a registered any-edge flag.
// Levels/pulses land DB_CYCLES+2 edges after a stable input; sw_any_edge trails the pulses by one cycle.
module sw_debounce_bank
  import sw_debounce_pkg::*;
#(
  parameter int N_SW      = NUM_SW,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input logic               clk,
  input logic               rst,
  sw_debounce_bank_if.slave bus
);

  logic [N_SW-1:0] level_w;
  logic [N_SW-1:0] rise_w;
  logic [N_SW-1:0] fall_w;
  logic            any_edge_q, any_edge_d;

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .sw_in(bus.sw_in[i]),
      .level(level_w[i]),
      .rise (rise_w[i]),
      .fall (fall_w[i])
    );
  end

  always_comb begin
    any_edge_d = |(rise_w | fall_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= any_edge_d;
    end
  end

  assign bus.sw_level    = level_w;
  assign bus.sw_rise     = rise_w;
  assign bus.sw_fall     = fall_w;
  assign bus.sw_any_edge = any_edge_q;

endmodule

// File: tb/tb_sw_debounce_bank.sv
// Directed bench for sw_debounce_bank with DB_CYCLES=4: a stimulus stays stable from
// sampling edge k and outputs are expected to move on edge k+6.
module tb_sw_debounce_bank;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sw_debounce_bank_if #(.N_SW(8)) bus ();

  sw_debounce_bank #(
    .N_SW     (8),
    .DB_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] lvl;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] lvl, input logic [7:0] rise,
                         input logic [7:0] fall, input logic any);
    chk({tag, " level"}, bus.sw_level, lvl);
    chk({tag, " rise"},  bus.sw_rise,  rise);
    chk({tag, " fall"},  bus.sw_fall,  fall);
    chk({tag, " any"},   {7'd0, bus.sw_any_edge}, {7'd0, any});
  endtask

  task automatic add(input int n, input logic [7:0] sw, input logic [7:0] lvl,
                     input logic [7:0] rise, input logic [7:0] fall, input logic any);
    vec_t v;
    v.sw = sw; v.lvl = lvl; v.rise = rise; v.fall = fall; v.any = any;
    repeat (n) tbl.push_back(v);
  endtask

  // Apply sw and walk 9 cycles: old level through step 6, pulse at step 7, any_edge at step 8.
  task automatic transition(input string tag, input logic [7:0] sw, input logic [7:0] lvl_old,
                            input logic [7:0] lvl_new, input logic [7:0] rise,
                            input logic [7:0] fall);
    bus.sw_in = sw;
    for (int s = 1; s <= 9; s++) begin
      @(negedge clk);
      chk_all($sformatf("%s step%0d", tag, s),
              (s >= 7) ? lvl_new : lvl_old,
              (s == 7) ? rise : 8'h00,
              (s == 7) ? fall : 8'h00,
              (s == 8));
    end
  endtask

  initial begin
    int         rise_cnt;
    int         rise_step;
    logic [7:0] other_pulses;

    n_cmp = 0;
    n_err = 0;

    // Reset with every switch already high.
    rst       = 1'b1;
    bus.sw_in = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_all($sformatf("in_reset c%0d", c), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    rst = 1'b0;
    transition("post_reset_rise", 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00);
    transition("all_release", 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF);

    // Clean press on ch3, simultaneous ch1/ch6 press and release, ch5 bounce rejection.
    add(6, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1, 8'h08, 8'h08, 8'h08, 8'h00, 1'b0);
    add(1, 8'h08, 8'h08, 8'h00, 8'h00, 1'b1);
    add(1, 8'h08, 8'h08, 8'h00, 8'h00, 1'b0);
    add(6, 8'h4A, 8'h08, 8'h00, 8'h00, 1'b0);
    add(1, 8'h4A, 8'h4A, 8'h42, 8'h00, 1'b0);
    add(1, 8'h4A, 8'h4A, 8'h00, 8'h00, 1'b1);
    add(1, 8'h4A, 8'h4A, 8'h00, 8'h00, 1'b0);
    add(6, 8'h08, 8'h4A, 8'h00, 8'h00, 1'b0);
    add(1, 8'h08, 8'h08, 8'h00, 8'h42, 1'b0);
    add(1, 8'h08, 8'h08, 8'h00, 8'h00, 1'b1);
    add(1, 8'h08, 8'h08, 8'h00, 8'h00, 1'b0);
    add(2, 8'h28, 8'h08, 8'h00, 8'h00, 1'b0);
    add(2, 8'h08, 8'h08, 8'h00, 8'h00, 1'b0);
    add(2, 8'h28, 8'h08, 8'h00, 8'h00, 1'b0);
    add(8, 8'h08, 8'h08, 8'h00, 8'h00, 1'b0);

    foreach (tbl[i]) begin
      bus.sw_in = tbl[i].sw;
      @(negedge clk);
      chk_all($sformatf("tbl row%0d", i + 1), tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].any);
    end

    // ch0 bounces high 2, low 1, then settles high from step 4: one rise at step 10.
    rise_cnt     = 0;
    rise_step    = 0;
    other_pulses = 8'h00;
    for (int s = 1; s <= 14; s++) begin
      bus.sw_in = (s == 3) ? 8'h08 : 8'h09;
      @(negedge clk);
      if (bus.sw_rise[0]) begin
        rise_cnt++;
        rise_step = s;
      end
      other_pulses = other_pulses | (bus.sw_rise & 8'hFE) | bus.sw_fall;
    end
    chk("settle rise count", 8'(rise_cnt), 8'd1);
    chk("settle rise step", 8'(rise_step), 8'd10);
    chk("settle other pulses", other_pulses, 8'h00);
    chk("settle level", bus.sw_level, 8'h09);

    // Raise ch2, then reset while it is still mid-debounce.
    bus.sw_in = 8'h0D;
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk);
      chk_all($sformatf("pre_abort step%0d", s), 8'h09, 8'h00, 8'h00, 1'b0);
    end
    rst = 1'b1;
    #1;
    chk_all("abort async clear", 8'h00, 8'h00, 8'h00, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_all($sformatf("abort hold c%0d", c), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    rst = 1'b0;
    transition("after_abort", 8'h0D, 8'h00, 8'h0D, 8'h0D, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
